// File: rtl/adc_sample_scheduler.sv
// -----------------------------------------------------------------------------
// adc_sample_scheduler
//
// Collects filtered samples from four sinc3 ADC channels (0 = current, 1 = V1,
// 2 = V2, 3 = temp) and serialises them onto a single valid/ready stream,
// tagged with the channel id, for the EKF front end.
//
// Each channel has a one-deep holding register. A round-robin arbiter moves
// pending samples into a registered output stage. Overwrites of an unread
// sample are counted as overruns. A frame pulse is raised once every enabled
// channel has delivered a fresh sample downstream.
//
// Optional feature (compile-time macro ADC_SCHED_TIMESTAMP_EN):
//   A free-running TS_W-bit counter is latched per channel at capture. The
//   latched value is presented on out_ts alongside out_data. When the macro is
//   undefined, the counter, the timestamp registers, the TS_W parameter and
//   the out_ts port do not exist.
//
// Ports
//   clk_20mhz    in   1         system clock
//   rst_n        in   1         asynchronous active-low reset
//   ch_value_in  in   4*DATA_W  {ch3,ch2,ch1,ch0} filtered values
//   ch_valid_in  in   4         per-channel single-cycle valid pulses
//   ch_enable    in   4         channel enable mask
//   out_valid    out  1         output sample valid
//   out_ready    in   1         downstream ready
//   out_data     out  DATA_W    output sample
//   out_ch       out  2         channel id of out_data
//   frame_valid  out  1         1-cycle pulse: all enabled channels delivered
//   overrun      out  4         sticky per-channel overrun flags
//   ovr_count    out  OVR_W     total overruns, saturating at all-ones
//   overrun_clr  in   1         clears overrun and ovr_count
//   out_ts       out  TS_W      capture timestamp (macro builds only)
// -----------------------------------------------------------------------------
module adc_sample_scheduler #(
    parameter int DATA_W = 16,
    parameter int OVR_W  = 8
`ifdef ADC_SCHED_TIMESTAMP_EN
    ,
    parameter int TS_W   = 32
`endif
) (
    input  logic                clk_20mhz,
    input  logic                rst_n,
    input  logic [4*DATA_W-1:0] ch_value_in,
    input  logic [3:0]          ch_valid_in,
    input  logic [3:0]          ch_enable,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [1:0]          out_ch,
    output logic                frame_valid,
    output logic [3:0]          overrun,
    output logic [OVR_W-1:0]    ovr_count,
    input  logic                overrun_clr
`ifdef ADC_SCHED_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]     out_ts
`endif
);

    // Output handshake: a transfer happens on every rising clock edge where
    // out_valid and out_ready are both high. While out_valid is high and
    // out_ready is low, out_data/out_ch (and out_ts) are held unchanged and
    // out_valid stays high. out_valid never depends combinationally on
    // out_ready.

    logic [DATA_W-1:0] hold [4];
    logic [3:0]        pend;
    logic [3:0]        seen;
    logic [3:0]        en_q;
    logic [1:0]        rr_ptr;

    logic [3:0]        capture;
    logic [3:0]        loaded;
    logic [3:0]        new_ovr;
    logic [3:0]        pend_next;
    logic [3:0]        pend_rot;
    logic [3:0]        hs_bits;
    logic [3:0]        covered;
    logic              handshake;
    logic              load_en;
    logic              grant_any;
    logic              frame_hit;
    logic              en_changed;
    logic [1:0]        grant_off;
    logic [1:0]        grant_idx;
    logic [2:0]        n_ovr;
    logic [OVR_W:0]    cnt_sum;
    logic [OVR_W-1:0]  cnt_next;

    always_comb begin
        capture   = ch_valid_in & ch_enable;
        handshake = out_valid & out_ready;
        load_en   = ~out_valid | out_ready;

        // Rotate pend so that bit 0 is the channel under the RR pointer. The
        // lowest set bit of the rotated vector is then the winner's distance
        // from the pointer. Scanning downwards lets the nearest one win.
        pend_rot  = 4'({pend, pend} >> rr_ptr);
        grant_off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (pend_rot[k]) begin
                grant_off = 2'(k);
            end
        end
        grant_idx = rr_ptr + grant_off;
        grant_any = |pend;

        loaded    = (load_en && grant_any) ? (4'b0001 << grant_idx) : 4'b0000;

        // A capture on top of an unread sample is an overrun unless that
        // sample is leaving for the output stage in the same cycle.
        new_ovr   = capture & pend & ~loaded;
        pend_next = ch_enable & (capture | (pend & ~loaded));

        n_ovr     = 3'(new_ovr[0]) + 3'(new_ovr[1]) + 3'(new_ovr[2]) + 3'(new_ovr[3]);
        cnt_sum   = {1'b0, ovr_count} + (OVR_W+1)'(n_ovr);
        if (overrun_clr) begin
            cnt_next = OVR_W'(n_ovr);
        end else if (cnt_sum[OVR_W]) begin
            cnt_next = '1;
        end else begin
            cnt_next = cnt_sum[OVR_W-1:0];
        end

        hs_bits    = handshake ? (4'b0001 << out_ch) : 4'b0000;
        covered    = seen | hs_bits;
        en_changed = (ch_enable != en_q);
        frame_hit  = handshake && (ch_enable != 4'b0000) &&
                     ((covered & ch_enable) == ch_enable);
    end

    // Holding registers and pending flags
    always_ff @(posedge clk_20mhz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                hold[i] <= '0;
            end
            pend <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (capture[i]) begin
                    hold[i] <= ch_value_in[i*DATA_W +: DATA_W];
                end
            end
            pend <= pend_next;
        end
    end

    // Output stage and round-robin pointer
    always_ff @(posedge clk_20mhz or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= 2'd0;
            rr_ptr    <= 2'd0;
        end else if (load_en) begin
            if (grant_any) begin
                out_valid <= 1'b1;
                out_data  <= hold[grant_idx];
                out_ch    <= grant_idx;
                rr_ptr    <= grant_idx + 2'd1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Overrun tracking and frame detection
    always_ff @(posedge clk_20mhz or negedge rst_n) begin
        if (!rst_n) begin
            overrun     <= 4'b0000;
            ovr_count   <= '0;
            frame_valid <= 1'b0;
            seen        <= 4'b0000;
            en_q        <= 4'b0000;
        end else begin
            // A new overrun in the clearing cycle survives the clear.
            overrun     <= overrun_clr ? new_ovr : (overrun | new_ovr);
            ovr_count   <= cnt_next;
            frame_valid <= frame_hit;
            seen        <= (frame_hit || en_changed) ? 4'b0000 : covered;
            en_q        <= ch_enable;
        end
    end

`ifdef ADC_SCHED_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts_hold [4];

    always_ff @(posedge clk_20mhz or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt <= '0;
            for (int i = 0; i < 4; i++) begin
                ts_hold[i] <= '0;
            end
            out_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (capture[i]) begin
                    ts_hold[i] <= ts_cnt;
                end
            end
            if (load_en && grant_any) begin
                out_ts <= ts_hold[grant_idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_scheduler
//
// Bench for adc_sample_scheduler. It uses a table of single-pulse vectors,
// hand-written multi-cycle sequences, and a randomized phase. Every cycle, the
// outputs are compared with a transaction-level reference model: per-channel
// mailboxes, a presented item, and a next-to-serve channel index.
// -----------------------------------------------------------------------------
module tb_adc_sample_scheduler;
    localparam int DATA_W = 16;
    localparam int OVR_W  = 8;
    localparam int CNT_MAX = (1 << OVR_W) - 1;
`ifdef ADC_SCHED_TIMESTAMP_EN
    localparam int TS_W = 32;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic                clk_20mhz;
    logic                rst_n;
    logic [4*DATA_W-1:0] ch_value_in;
    logic [3:0]          ch_valid_in;
    logic [3:0]          ch_enable;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          out_ch;
    logic                frame_valid;
    logic [3:0]          overrun;
    logic [OVR_W-1:0]    ovr_count;
    logic                overrun_clr;
`ifdef ADC_SCHED_TIMESTAMP_EN
    logic [TS_W-1:0]     out_ts;
`endif

    initial clk_20mhz = 1'b0;
    always #25 clk_20mhz = ~clk_20mhz;

    adc_sample_scheduler #(
        .DATA_W(DATA_W),
        .OVR_W (OVR_W)
`ifdef ADC_SCHED_TIMESTAMP_EN
        ,
        .TS_W  (TS_W)
`endif
    ) dut (
        .clk_20mhz  (clk_20mhz),
        .rst_n      (rst_n),
        .ch_value_in(ch_value_in),
        .ch_valid_in(ch_valid_in),
        .ch_enable  (ch_enable),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .frame_valid(frame_valid),
        .overrun    (overrun),
        .ovr_count  (ovr_count),
        .overrun_clr(overrun_clr)
`ifdef ADC_SCHED_TIMESTAMP_EN
        ,
        .out_ts     (out_ts)
`endif
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] m_val [4];
    bit                m_full [4];
    bit                m_ov;
    logic [DATA_W-1:0] m_od;
    int                m_och;
    int                m_next;
    logic [3:0]        m_seen;
    logic [3:0]        m_prev_en;
    logic [3:0]        m_ovr;
    int                m_cnt;
    bit                m_frame;
`ifdef ADC_SCHED_TIMESTAMP_EN
    logic [TS_W-1:0]   m_tsc;
    logic [TS_W-1:0]   m_tslot [4];
    logic [TS_W-1:0]   m_ots;
`endif

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_val[i]  = '0;
            m_full[i] = 1'b0;
        end
        m_ov = 1'b0; m_od = '0; m_och = 0; m_next = 0;
        m_seen = 4'b0; m_prev_en = 4'b0; m_ovr = 4'b0; m_cnt = 0; m_frame = 1'b0;
`ifdef ADC_SCHED_TIMESTAMP_EN
        m_tsc = '0; m_ots = '0;
        for (int i = 0; i < 4; i++) m_tslot[i] = '0;
`endif
    endtask

    // Advance the model by one clock using the inputs applied during the cycle.
    task automatic model_step();
        bit hs, can_load, taken;
        int pick, n;
        logic [3:0] cap, new_ovr, covered;
        hs       = m_ov && out_ready;
        can_load = !m_ov || out_ready;
        pick = -1;
        if (can_load) begin
            for (int k = 0; k < 4; k++) begin
                if (pick < 0 && m_full[(m_next + k) % 4]) pick = (m_next + k) % 4;
            end
        end
        cap = ch_valid_in & ch_enable;

        m_frame = 1'b0;
        if (hs) begin
            covered = m_seen | (4'b0001 << m_och);
            if (ch_enable != 4'b0 && (covered & ch_enable) == ch_enable) begin
                m_frame = 1'b1;
                m_seen  = 4'b0;
            end else begin
                m_seen = covered;
            end
        end
        if (ch_enable != m_prev_en) m_seen = 4'b0;
        m_prev_en = ch_enable;

        if (pick >= 0) begin
            m_ov = 1'b1; m_od = m_val[pick]; m_och = pick; m_next = (pick + 1) % 4;
`ifdef ADC_SCHED_TIMESTAMP_EN
            m_ots = m_tslot[pick];
`endif
        end else if (can_load) begin
            m_ov = 1'b0;
        end

        n = 0; new_ovr = 4'b0;
        for (int i = 0; i < 4; i++) begin
            taken = (pick == i);
            if (cap[i] && m_full[i] && !taken) begin
                n++;
                new_ovr[i] = 1'b1;
            end
            if (cap[i]) begin
                m_val[i] = ch_value_in[i*DATA_W +: DATA_W];
`ifdef ADC_SCHED_TIMESTAMP_EN
                m_tslot[i] = m_tsc;
`endif
            end
            m_full[i] = ch_enable[i] && (cap[i] || (m_full[i] && !taken));
        end
        if (overrun_clr) begin
            m_ovr = new_ovr;
            m_cnt = n;
        end else begin
            m_ovr = m_ovr | new_ovr;
            m_cnt = (m_cnt + n > CNT_MAX) ? CNT_MAX : m_cnt + n;
        end
`ifdef ADC_SCHED_TIMESTAMP_EN
        m_tsc = m_tsc + 1'b1;
`endif
    endtask

    task automatic compare_model();
        check("model_out_valid", out_valid, m_ov);
        if (m_ov) begin
            check("model_out_data", out_data, m_od);
            check("model_out_ch", out_ch, m_och);
`ifdef ADC_SCHED_TIMESTAMP_EN
            check("model_out_ts", out_ts, m_ots);
`endif
        end
        check("model_frame_valid", frame_valid, m_frame);
        check("model_overrun", overrun, m_ovr);
        check("model_ovr_count", ovr_count, m_cnt);
    endtask

    // ---------------- driver tasks ----------------
    // One clock: the model consumes the inputs held during the cycle, and the
    // DUT outputs are then sampled 1 ns after the edge.
    task automatic cycle();
        @(posedge clk_20mhz);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic set_val(input int ch, input logic [DATA_W-1:0] v);
        ch_value_in[ch*DATA_W +: DATA_W] = v;
    endtask

    // ---------------- table of single-pulse vectors ----------------
    typedef struct {
        int                ch;
        logic [DATA_W-1:0] val;
        logic [3:0]        en;
        bit                exp_valid;
    } vec_t;
    vec_t vecs[6];

    // ---------------- main test ----------------
    initial begin
        int prev_ch, vcount, vlast, fpos, fcount;
        logic [3:0] vmask;
`ifdef ADC_SCHED_TIMESTAMP_EN
        logic [TS_W-1:0] ts_n;
`endif
        vecs[0] = '{ch: 2, val: 16'h1234, en: 4'hF, exp_valid: 1'b1};
        vecs[1] = '{ch: 0, val: 16'h0BEE, en: 4'hF, exp_valid: 1'b1};
        vecs[2] = '{ch: 3, val: 16'hFFFF, en: 4'hF, exp_valid: 1'b1};
        vecs[3] = '{ch: 1, val: 16'h0000, en: 4'h2, exp_valid: 1'b1};
        vecs[4] = '{ch: 1, val: 16'h5555, en: 4'hD, exp_valid: 1'b0};
        vecs[5] = '{ch: 0, val: 16'h8001, en: 4'h1, exp_valid: 1'b1};

        rst_n = 1'b0;
        ch_value_in = '0; ch_valid_in = 4'b0; ch_enable = 4'b0;
        out_ready = 1'b0; overrun_clr = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk_20mhz);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_ovr_count", ovr_count, 0);
`ifdef ADC_SCHED_TIMESTAMP_EN
        check("rst_out_ts", out_ts, 0);
`endif
        #10 rst_n = 1'b1;

        // All four channels in one cycle: served 0,1,2,3, then the frame pulse
        ch_enable = 4'hF; out_ready = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) set_val(i, 16'h00A0 + 16'(i));
        ch_valid_in = 4'hF;
        cycle();
        ch_valid_in = 4'b0;
        check("t2_latency", out_valid, 0);
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h00A0 + 16'(i));
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t2_valid", out_valid, 1);
            check("t2_ch", out_ch, i);
            check("t2_data", out_data, exp_q.pop_front());
            check("t2_frame_early", frame_valid, 0);
        end
        cycle();
        check("t2_frame", frame_valid, 1);
        check("t2_drained", out_valid, 0);
        cycle();
        check("t2_frame_single", frame_valid, 0);

        // Single pulses from the table: out_valid exactly at N+2
        for (int v = 0; v < 6; v++) begin
            ch_enable = vecs[v].en;
            cycle();
            cycle();
            set_val(vecs[v].ch, vecs[v].val);
            ch_valid_in = 4'b0001 << vecs[v].ch;
`ifdef ADC_SCHED_TIMESTAMP_EN
            ts_n = m_tsc;
`endif
            cycle();
            ch_valid_in = 4'b0;
            check("tv_n1_valid", out_valid, 0);
            cycle();
            check("tv_valid", out_valid, vecs[v].exp_valid);
            if (vecs[v].exp_valid) begin
                check("tv_data", out_data, vecs[v].val);
                check("tv_ch", out_ch, vecs[v].ch);
`ifdef ADC_SCHED_TIMESTAMP_EN
                check("tv_ts", out_ts, ts_n);
`endif
            end
            cycle();
            check("tv_single", out_valid, 0);
        end

        // Overwrite while stalled: ch1 gets 1,2,3 with ready low
        ch_enable = 4'hF; out_ready = 1'b0;
        cycle();
        for (int i = 1; i <= 3; i++) begin
            set_val(1, 16'(i));
            ch_valid_in = 4'b0010;
            cycle();
        end
        ch_valid_in = 4'b0;
        check("t3_overrun", overrun, 4'b0010);
        check("t3_ovr_count", ovr_count, 1);
        check("t3_stall_data", out_data, 16'h0001);
        out_ready = 1'b1;
        cycle();
        check("t3_second_valid", out_valid, 1);
        check("t3_second_data", out_data, 16'h0003);
        cycle();
        check("t3_empty", out_valid, 0);
        overrun_clr = 1'b1;
        cycle();
        overrun_clr = 1'b0;
        check("t3_clr_flags", overrun, 0);
        check("t3_clr_count", ovr_count, 0);

        // ch0 and ch1 every cycle: grants alternate
        prev_ch = -1;
        for (int c = 0; c < 14; c++) begin
            set_val(0, 16'h4000 + 16'(c));
            set_val(1, 16'h5000 + 16'(c));
            ch_valid_in = 4'b0011;
            cycle();
            if (out_valid) begin
                if (prev_ch >= 0) check("t4_alternate", out_ch, (prev_ch == 0) ? 1 : 0);
                prev_ch = int'(out_ch);
            end
        end
        check("t4_saw_grants", prev_ch >= 0, 1);
        ch_valid_in = 4'b0;
        repeat (3) cycle();
        overrun_clr = 1'b1;
        cycle();
        overrun_clr = 1'b0;

        // Partial enable mask: only ch0 and ch2 delivered, frame after both
        ch_enable = 4'b0101;
        cycle();
        cycle();
        for (int i = 0; i < 4; i++) set_val(i, 16'h00B0 + 16'(i));
        ch_valid_in = 4'hF;
        cycle();
        ch_valid_in = 4'b0;
        vmask = 4'b0; vcount = 0; vlast = -1; fpos = -1; fcount = 0;
        for (int j = 0; j < 6; j++) begin
            cycle();
            if (out_valid) begin
                vmask = vmask | (4'b0001 << out_ch);
                vcount++;
                vlast = j;
            end
            if (frame_valid) begin
                fcount++;
                fpos = j;
            end
        end
        check("t5_channels", vmask, 4'b0101);
        check("t5_count", vcount, 2);
        check("t5_frame_count", fcount, 1);
        check("t5_frame_pos", fpos, vlast + 1);

        // Reset mid-operation: out_valid drops at once, pending data lost
        ch_enable = 4'hF; out_ready = 1'b0;
        cycle();
        set_val(0, 16'h0C00); set_val(1, 16'h0C01);
        ch_valid_in = 4'b0011;
        cycle();
        ch_valid_in = 4'b0;
        cycle();
        check("t6_pre_valid", out_valid, 1);
        #10 rst_n = 1'b0;
        #1;
        check("t6_async_valid", out_valid, 0);
        check("t6_async_overrun", overrun, 0);
        model_reset();
        #10 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            cycle();
            check("t6_no_ghost", out_valid, 0);
        end

        // Counter saturation, then clearing
        out_ready = 1'b0;
        for (int j = 0; j < 262; j++) begin
            set_val(0, 16'(j));
            ch_valid_in = 4'b0001;
            cycle();
        end
        ch_valid_in = 4'b0;
        check("t6_saturated", ovr_count, CNT_MAX);
        overrun_clr = 1'b1;
        cycle();
        check("t6_clr_count", ovr_count, 0);
        check("t6_clr_flags", overrun, 0);
        // Clear coinciding with a new overrun: the overrun wins
        ch_valid_in = 4'b0001;
        set_val(0, 16'h0DDD);
        cycle();
        overrun_clr = 1'b0;
        ch_valid_in = 4'b0;
        check("t6_clr_race_flag", overrun, 4'b0001);
        check("t6_clr_race_count", ovr_count, 1);
        out_ready = 1'b1;
        repeat (4) cycle();

        // Randomized traffic against the model
        for (int j = 0; j < 600; j++) begin
            if (j % 97 == 0) ch_enable = 4'($urandom_range(0, 15));
            ch_valid_in = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            ch_value_in = {$urandom(), $urandom()};
            out_ready   = ($urandom_range(0, 3) != 0);
            overrun_clr = ($urandom_range(0, 40) == 0);
            cycle();
        end
        ch_valid_in = 4'b0; overrun_clr = 1'b0; out_ready = 1'b1;
        repeat (6) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
